// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder. The master drives the operands,
// and the slave returns status and the held result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock through two half-adder stages with a registered
// carry. It computes {cout,sum} = a + b + cin in WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             p;
    logic             g;
    logic             s;
    logic             carry_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic             last_bit;

    // One bit step: half adder on the operand bits, a second half adder with the carry.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        acc_nxt            = acc >> 1;
        p                  = sh_a[0] ^ sh_b[0];
        g                  = sh_a[0] & sh_b[0];
        s                  = p ^ carry;
        carry_nxt          = g | (p & carry);
        acc_nxt[WIDTH-1]   = s;
        last_bit           = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sh_a   <= bus.a;
                        sh_b   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    acc   <= acc_nxt;
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        // The result register is the only place sum/cout change outside reset.
                        sum_q  <= acc_nxt;
                        cout_q <= carry_nxt;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vectors on a WIDTH=8 instance, plus exhaustive
// back-to-back runs on WIDTH=4 and WIDTH=1. A cycle-level model is compared every cycle.
module tb_serial_adder;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [N];
    logic        start_v [N];
    logic [63:0] a_v     [N];
    logic [63:0] b_v     [N];
    logic        cin_v   [N];
    logic        busy_o  [N];
    logic        done_o  [N];
    logic        cout_o  [N];
    logic [63:0] sum_o   [N];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit checking = 1'b0;

    serial_adder_if #(.WIDTH(8)) if0 ();
    serial_adder_if #(.WIDTH(4)) if1 ();
    serial_adder_if #(.WIDTH(1)) if2 ();

    assign if0.start = start_v[0];
    assign if0.a     = a_v[0][7:0];
    assign if0.b     = b_v[0][7:0];
    assign if0.cin   = cin_v[0];
    assign if1.start = start_v[1];
    assign if1.a     = a_v[1][3:0];
    assign if1.b     = b_v[1][3:0];
    assign if1.cin   = cin_v[1];
    assign if2.start = start_v[2];
    assign if2.a     = a_v[2][0:0];
    assign if2.b     = b_v[2][0:0];
    assign if2.cin   = cin_v[2];

    assign busy_o[0] = if0.busy;
    assign done_o[0] = if0.done;
    assign cout_o[0] = if0.cout;
    assign sum_o[0]  = 64'(if0.sum);
    assign busy_o[1] = if1.busy;
    assign done_o[1] = if1.done;
    assign cout_o[1] = if1.cout;
    assign sum_o[1]  = 64'(if1.sum);
    assign busy_o[2] = if2.busy;
    assign done_o[2] = if2.done;
    assign cout_o[2] = if2.cout;
    assign sum_o[2]  = 64'(if2.sum);

    serial_adder #(.WIDTH(8)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(if0));
    serial_adder #(.WIDTH(4)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(if1));
    serial_adder #(.WIDTH(1)) dut2 (.clk(clk), .rst(rst_v[2]), .bus(if2));

    function automatic int wid(input int i);
        return (i == 0) ? 8 : (i == 1) ? 4 : 1;
    endfunction

    function automatic logic [63:0] mask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: counts edges since acceptance. The result appears WIDTH edges later, and
    // the state is idle again one edge after that.
    int          m_t    [N];
    logic        m_busy [N];
    logic        m_done [N];
    logic        m_cout [N];
    logic [63:0] m_sum  [N];
    logic [64:0] m_pend [N];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rst_v[i]) begin
                m_t[i] = -1; m_busy[i] = 0; m_done[i] = 0; m_sum[i] = '0; m_cout[i] = 0;
            end else if (m_t[i] < 0) begin
                if (start_v[i]) begin
                    m_pend[i] = {1'b0, a_v[i] & mask(wid(i))} + {1'b0, b_v[i] & mask(wid(i))}
                                + 65'(cin_v[i]);
                    m_t[i] = 0;
                    m_busy[i] = 1;
                end
            end else begin
                m_t[i]++;
                if (m_t[i] == wid(i)) begin
                    m_busy[i] = 0;
                    m_done[i] = 1;
                    m_sum[i]  = m_pend[i][63:0] & mask(wid(i));
                    m_cout[i] = m_pend[i][wid(i)];
                end else if (m_t[i] == wid(i) + 1) begin
                    m_done[i] = 0;
                    m_t[i] = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("w%0d_busy", wid(i)), 64'(busy_o[i]), 64'(m_busy[i]));
                check($sformatf("w%0d_done", wid(i)), 64'(done_o[i]), 64'(m_done[i]));
                check($sformatf("w%0d_sum", wid(i)),  sum_o[i], m_sum[i]);
                check($sformatf("w%0d_cout", wid(i)), 64'(cout_o[i]), 64'(m_cout[i]));
            end
        end
    end

    // Single-cycle start. It returns at the first negedge after the accepting edge.
    task automatic pulse(input int i, input logic [63:0] a, input logic [63:0] b, input logic cin);
        start_v[i] = 1'b1; a_v[i] = a; b_v[i] = b; cin_v[i] = cin;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic count_dones(input int i, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done_o[i] === 1'b1) cnt++;
        end
    endtask

    // WIDTH=8 operation: latency and busy length, then the result and a one-cycle done.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] exp_sum, input logic exp_cout);
        int lat = 0;
        int bc = 0;
        pulse(0, 64'(a), 64'(b), cin);
        while (done_o[0] !== 1'b1 && lat < 40) begin
            if (busy_o[0] === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd8);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd8);
        check({tag, "_sum"}, sum_o[0], 64'(exp_sum));
        check({tag, "_cout"}, 64'(cout_o[0]), 64'(exp_cout));
        @(negedge clk);
        check({tag, "_done_width"}, 64'(done_o[0]), 64'd0);
    endtask

    // Exhaustive back-to-back run with start held high.
    task automatic exh(input int i);
        int w = wid(i);
        int prev = -1;
        int lat;
        logic [64:0] exp;
        start_v[i] = 1'b1;
        for (int v = 0; v < (1 << (2 * w + 1)); v++) begin
            a_v[i]   = 64'(v) & mask(w);
            b_v[i]   = (64'(v) >> w) & mask(w);
            cin_v[i] = 1'(v >> (2 * w));
            exp = 65'(a_v[i]) + 65'(b_v[i]) + 65'(cin_v[i]);
            @(negedge clk);
            lat = 0;
            while (done_o[i] !== 1'b1 && lat < 3 * w + 10) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("w%0d_done_seen", w), 64'(done_o[i]), 64'd1);
            if (prev >= 0) check($sformatf("w%0d_spacing", w), 64'(cyc - prev), 64'(w + 2));
            prev = cyc;
            check($sformatf("w%0d_result_%0h_%0h_%0d", w, a_v[i], b_v[i], cin_v[i]),
                  (64'(cout_o[i]) << w) | sum_o[i], exp[63:0]);
        end
        start_v[i] = 1'b0;
    endtask

    initial begin
        int nd;
        int hold_bad;
        int lat;
        for (int i = 0; i < N; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0;
            m_t[i] = -1; m_busy[i] = 0; m_done[i] = 0; m_sum[i] = '0; m_cout[i] = 0; m_pend[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) rst_v[i] = 1'b0;
        checking = 1'b1;
        check("reset_busy", 64'(busy_o[0]), 64'd0);
        check("reset_done", 64'(done_o[0]), 64'd0);
        check("reset_sum",  sum_o[0], 64'd0);
        check("reset_cout", 64'(cout_o[0]), 64'd0);
        @(negedge clk);

        op8("basic", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        op8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8("allones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // A second start during RUN must be ignored.
        pulse(0, 64'h10, 64'h20, 1'b0);
        @(negedge clk);
        @(negedge clk);
        pulse(0, 64'hAA, 64'h55, 1'b0);
        lat = 0;
        while (done_o[0] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("restart_sum", sum_o[0], 64'h30);
        check("restart_cout", 64'(cout_o[0]), 64'd0);
        count_dones(0, 15, nd);
        check("restart_extra_done", 64'(nd), 64'd0);
        op8("after_restart", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

        // The previous result is held until the done cycle.
        pulse(0, 64'h01, 64'h01, 1'b0);
        hold_bad = 0;
        lat = 0;
        while (done_o[0] !== 1'b1 && lat < 40) begin
            if (sum_o[0] !== 64'h4B) hold_bad++;
            @(negedge clk);
            lat++;
        end
        check("hold_during_run", 64'(hold_bad), 64'd0);
        check("hold_new_sum", sum_o[0], 64'h02);
        @(negedge clk);

        // A reset mid-RUN aborts the operation and clears the result.
        pulse(0, 64'h11, 64'h22, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        check("abort_busy", 64'(busy_o[0]), 64'd0);
        check("abort_done", 64'(done_o[0]), 64'd0);
        check("abort_sum",  sum_o[0], 64'd0);
        check("abort_cout", 64'(cout_o[0]), 64'd0);
        count_dones(0, 15, nd);
        check("abort_no_done", 64'(nd), 64'd0);
        op8("post_abort", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0);

        fork
            exh(1);
            exh(2);
        join

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
